// File: rtl/rv32i_lsu_mem_master.sv
// rtl/rv32i_lsu_mem_master.sv - RV32I load/store unit driving a byte-addressed RAM port
`ifndef MEM_READ
`define MEM_READ       2'd0
`define MEM_WRITE_WORD 2'd1
`define MEM_WRITE_HALF 2'd2
`define MEM_WRITE_BYTE 2'd3
`endif

module rv32i_lsu_mem_master #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic [1:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_value,
    input  logic [31:0]           mem_value
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_fault_q, resp_fault_d;
    logic [1:0]            mem_mode_q, mem_mode_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [31:0]           mem_write_value_q, mem_write_value_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  fault_q, fault_d;

    logic                  accept_fault;
    logic [31:0]           load_data;
    logic [7:0]            b0, b1, b2, b3;

    // RAM returns the byte at the access address in the top lane
    assign b0 = mem_value[31:24];
    assign b1 = mem_value[23:16];
    assign b2 = mem_value[15:8];
    assign b3 = mem_value[7:0];

    always_comb begin
        accept_fault = (req_addr[31:ADDR_WIDTH] != '0);
        if (req_write) begin
            if (req_funct3 > 3'b010) accept_fault = 1'b1;
        end else begin
            if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
                accept_fault = 1'b1;
        end
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{b0[7]}}, b0};
            3'b001:  load_data = {{16{b1[7]}}, b1, b0};
            3'b010:  load_data = {b3, b2, b1, b0};
            3'b100:  load_data = {24'd0, b0};
            3'b101:  load_data = {16'd0, b1, b0};
            default: load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        req_ready_d       = req_ready_q;
        resp_valid_d      = resp_valid_q;
        resp_rdata_d      = resp_rdata_q;
        resp_fault_d      = resp_fault_q;
        mem_mode_d        = mem_mode_q;
        mem_address_d     = mem_address_q;
        mem_write_value_d = mem_write_value_q;
        write_d           = write_q;
        funct3_d          = funct3_q;
        fault_d           = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d       = ACCESS;
                    req_ready_d   = 1'b0;
                    write_d       = req_write;
                    funct3_d      = req_funct3;
                    fault_d       = accept_fault;
                    mem_address_d = req_addr[ADDR_WIDTH-1:0];
                    if (req_write && !accept_fault) begin
                        mem_write_value_d = req_wdata;
                        case (req_funct3)
                            3'b000:  mem_mode_d = `MEM_WRITE_BYTE;
                            3'b001:  mem_mode_d = `MEM_WRITE_HALF;
                            default: mem_mode_d = `MEM_WRITE_WORD;
                        endcase
                    end
                end
            end
            ACCESS: begin
                // RAM samples the write mode at this edge; drop back to the side-effect-free code
                mem_mode_d = `MEM_READ;
                state_d    = CAPTURE;
            end
            CAPTURE: begin
                resp_valid_d = 1'b1;
                resp_fault_d = fault_q;
                resp_rdata_d = (fault_q || write_q) ? 32'd0 : load_data;
                state_d      = RESP;
            end
            default: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            req_ready_q       <= 1'b1;
            resp_valid_q      <= 1'b0;
            resp_rdata_q      <= 32'd0;
            resp_fault_q      <= 1'b0;
            mem_mode_q        <= `MEM_READ;
            mem_address_q     <= '0;
            mem_write_value_q <= 32'd0;
            write_q           <= 1'b0;
            funct3_q          <= 3'd0;
            fault_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            req_ready_q       <= req_ready_d;
            resp_valid_q      <= resp_valid_d;
            resp_rdata_q      <= resp_rdata_d;
            resp_fault_q      <= resp_fault_d;
            mem_mode_q        <= mem_mode_d;
            mem_address_q     <= mem_address_d;
            mem_write_value_q <= mem_write_value_d;
            write_q           <= write_d;
            funct3_q          <= funct3_d;
            fault_q           <= fault_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_fault      = resp_fault_q;
    assign mem_mode        = mem_mode_q;
    assign mem_address     = mem_address_q;
    assign mem_write_value = mem_write_value_q;

endmodule
